// File: rtl/fir_pkg.sv
// Shared definitions for the time-multiplexed FIR multiplier scheduler:
// FSM state encoding, product tag bit positions and accumulator sizing.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Bit positions inside the {last, valid} tag carried alongside each product.
  localparam int TAG_VALID = 0;
  localparam int TAG_LAST  = 1;

  // Full-precision accumulator width: product width plus growth for TAPS terms.
  function automatic int acc_width(input int width, input int taps);
    return 2 * width + $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// TAPS x WIDTH coefficient register file. Writes are accepted only while the
// scheduler is idle; reads are combinational, addressed by the tap index.
module fir_coeff_bank
  import fir_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAPS  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    idle,
  input  logic                    we,
  input  logic [$clog2(TAPS)-1:0] wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic [$clog2(TAPS)-1:0] rd_addr,
  output logic [WIDTH-1:0]        rd_data
);

  logic [WIDTH-1:0] coeff_q [TAPS];
  logic [WIDTH-1:0] coeff_d [TAPS];

  // Next coefficient contents: a write lands only when the scheduler is idle.
  always_comb begin
    coeff_d = coeff_q;
    if (we && idle) begin
      coeff_d[wr_addr] = wr_data;
    end
  end

  // Coefficient storage with asynchronous clear.
  // NOTE: this small register file is deliberately reset so the filter starts
  // from a known all-zero response; large RAM-style arrays normally are not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        coeff_q[i] <= '0;
      end
    end else begin
      coeff_q <= coeff_d;
    end
  end

  assign rd_data = coeff_q[rd_addr];

endmodule

// File: rtl/fir_mult_scheduler.sv
// Direct-form FIR that shares one external pipelined multiplier across all
// taps: one coefficient x sample product is issued per cycle with a
// {last, valid} tag, returning products are accumulated, and one result is
// presented per accepted sample.
// Build option: define SAT_OUT_EN to clamp out_data to all-ones on overflow;
// otherwise out_data carries the low 2*WIDTH bits of the sum (wraps).
module fir_mult_scheduler
  import fir_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAPS  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_data,
  input  logic                    coeff_we,
  input  logic [$clog2(TAPS)-1:0] coeff_addr,
  input  logic [WIDTH-1:0]        coeff_data,
  output logic [WIDTH-1:0]        mult_x,
  output logic [WIDTH-1:0]        mult_y,
  output logic [1:0]              mult_ctrl_in,
  input  logic [2*WIDTH-1:0]      mult_result,
  input  logic [1:0]              mult_ctrl_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*WIDTH-1:0]      out_data,
  output logic                    out_ovf
);

  localparam int KW    = $clog2(TAPS);
  localparam int PW    = 2 * WIDTH;
  localparam int ACC_W = acc_width(WIDTH, TAPS);
  localparam logic [KW-1:0] K_LAST = KW'(TAPS - 1);

  state_e            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  sample_q [TAPS];
  logic [WIDTH-1:0]  sample_d [TAPS];
  logic [PW-1:0]     out_data_q, out_data_d;
  logic              out_ovf_q, out_ovf_d;

  logic              accept;
  logic              tag_valid;
  logic              tag_last;
  logic [ACC_W-1:0]  acc_sum;
  logic              sum_ovf;
  logic [WIDTH-1:0]  coeff_rd;

  assign accept    = (state_q == IDLE) && in_valid;
  assign tag_valid = mult_ctrl_out[TAG_VALID];
  assign tag_last  = mult_ctrl_out[TAG_LAST];

  fir_coeff_bank #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_coeff_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .idle    (state_q == IDLE),
    .we      (coeff_we),
    .wr_addr (coeff_addr),
    .wr_data (coeff_data),
    .rd_addr (k_q),
    .rd_data (coeff_rd)
  );

  // FSM state register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // its pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: issue TAPS products, wait for the tagged last one, hold the result.
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)              state_d = ISSUE;
      ISSUE:   if (k_q == K_LAST)         state_d = DRAIN;
      DRAIN:   if (tag_valid && tag_last) state_d = DONE;
      DONE:    if (out_ready)             state_d = IDLE;
      default:                            state_d = IDLE;
    endcase
  end

  // FSM outputs: handshakes and the tagged operand pair for the multiplier.
  always_comb begin
    in_ready     = (state_q == IDLE);
    out_valid    = (state_q == DONE);
    mult_x       = '0;
    mult_y       = '0;
    mult_ctrl_in = '0;
    if (state_q == ISSUE) begin
      mult_x                  = coeff_rd;
      mult_y                  = sample_q[k_q];
      mult_ctrl_in[TAG_VALID] = 1'b1;
      mult_ctrl_in[TAG_LAST]  = (k_q == K_LAST);
    end
  end

  // Datapath next-state: delay-line shift, tap counter, accumulation, result capture.
  always_comb begin
    k_d        = k_q;
    acc_d      = acc_q;
    sample_d   = sample_q;
    out_data_d = out_data_q;
    out_ovf_d  = out_ovf_q;
    acc_sum    = acc_q + ACC_W'(mult_result);
    sum_ovf    = |acc_sum[ACC_W-1:PW];

    if (accept) begin
      sample_d[0] = in_data;
      for (int i = 1; i < TAPS; i++) begin
        sample_d[i] = sample_q[i-1];
      end
      k_d   = '0;
      acc_d = '0;
    end

    if (state_q == ISSUE) begin
      k_d = k_q + KW'(1);
    end

    // Only tagged-valid products count; the tagged-last one closes the sum.
    if ((state_q == ISSUE || state_q == DRAIN) && tag_valid) begin
      acc_d = acc_sum;
      if (tag_last) begin
        out_ovf_d = sum_ovf;
`ifdef SAT_OUT_EN
        out_data_d = sum_ovf ? {PW{1'b1}} : acc_sum[PW-1:0];
`else
        out_data_d = acc_sum[PW-1:0];
`endif
      end
    end
  end

  // Datapath registers, all cleared by reset (including the delay line).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q        <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
      out_ovf_q  <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        sample_q[i] <= '0;
      end
    end else begin
      k_q        <= k_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      out_ovf_q  <= out_ovf_d;
      sample_q   <= sample_d;
    end
  end

  assign out_data = out_data_q;
  assign out_ovf  = out_ovf_q;

endmodule
